// File: rtl/crack_dispatcher.sv
// crack_dispatcher
//   Splits a 4-character password search across NUM_WORKERS cracker workers.
//   Each worker gets a fixed range of top-digit values. The dispatcher checks
//   the password, holds the workers in reset for two load cycles, releases
//   them, and waits for a match, for every worker to finish, or for the cycle
//   counter to saturate. It then reports the result with a one-cycle pulse.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle search request (only honoured in IDLE)
//   password[31:0]      four ASCII chars, [7:0] least-significant digit
//   worker_found/done   per-worker match / range-exhausted flags
//   worker_rst          per-worker reset/load strobe (low only in RUN)
//   worker_pwd          captured password broadcast to the workers
//   worker_from/to      packed 6-bit top-digit range per worker
//   busy                high in LOAD and RUN
//   result_valid        one-cycle pulse in REPORT
//   found, found_worker, timeout, pwd_invalid, cycles   result fields
//
// state  | meaning
// IDLE   | waiting for start; workers held in reset
// LOAD   | two cycles of worker reset/load with the captured password
// RUN    | workers released; count cycles and watch the flags
// REPORT | result_valid pulse, then back to IDLE
module crack_dispatcher #(
  parameter int NUM_WORKERS = 4,
  parameter int CYCLE_W     = 24,
  localparam int IDX_W      = (NUM_WORKERS > 2) ? $clog2(NUM_WORKERS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [31:0]              password,
  input  logic [NUM_WORKERS-1:0]   worker_found,
  input  logic [NUM_WORKERS-1:0]   worker_done,
  output logic [NUM_WORKERS-1:0]   worker_rst,
  output logic [31:0]              worker_pwd,
  output logic [6*NUM_WORKERS-1:0] worker_from,
  output logic [6*NUM_WORKERS-1:0] worker_to,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     found,
  output logic [IDX_W-1:0]         found_worker,
  output logic                     timeout,
  output logic                     pwd_invalid,
  output logic [CYCLE_W-1:0]       cycles
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_REPORT} state_t;

  localparam logic [CYCLE_W-1:0] CYC_MAX = {CYCLE_W{1'b1}};

  state_t             state_q, state_d;
  logic               load_cnt_q, load_cnt_d;
  logic [31:0]        pwd_q, pwd_d;
  logic               found_q, found_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               timeout_q, timeout_d;
  logic               inv_q, inv_d;
  logic [CYCLE_W-1:0] cycles_q, cycles_d;

  logic               pwd_ok;
  logic [IDX_W-1:0]   low_idx;
  logic [CYCLE_W-1:0] cycles_inc;

  for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_range
    assign worker_from[6*g +: 6] = 6'((36 * g) / NUM_WORKERS);
    assign worker_to[6*g +: 6]   = 6'((36 * (g + 1)) / NUM_WORKERS - 1);
  end

  always_comb begin
    pwd_ok = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (password[8*b +: 8] < 8'd48 || password[8*b +: 8] > 8'd83) pwd_ok = 1'b0;
    end
  end

  // Scan from the top so the lowest set index wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (worker_found[i]) low_idx = IDX_W'(i);
    end
  end

  assign cycles_inc = (cycles_q == CYC_MAX) ? CYC_MAX : cycles_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    pwd_d      = pwd_q;
    found_d    = found_q;
    idx_d      = idx_q;
    timeout_d  = timeout_q;
    inv_d      = inv_q;
    cycles_d   = cycles_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pwd_d     = password;
          found_d   = 1'b0;
          idx_d     = '0;
          timeout_d = 1'b0;
          cycles_d  = '0;
          if (pwd_ok) begin
            inv_d      = 1'b0;
            load_cnt_d = 1'b1;
            state_d    = S_LOAD;
          end else begin
            inv_d   = 1'b1;
            state_d = S_REPORT;
          end
        end
      end
      S_LOAD: begin
        if (load_cnt_q == 1'b0) begin
          cycles_d = '0;
          state_d  = S_RUN;
        end else begin
          load_cnt_d = load_cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        cycles_d = cycles_inc;
        if (|worker_found) begin
          found_d = 1'b1;
          idx_d   = low_idx;
          state_d = S_REPORT;
        end else if (&worker_done) begin
          state_d = S_REPORT;
        end else if (cycles_inc == CYC_MAX) begin
          timeout_d = 1'b1;
          state_d   = S_REPORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      load_cnt_q <= 1'b0;
      pwd_q      <= '0;
      found_q    <= 1'b0;
      idx_q      <= '0;
      timeout_q  <= 1'b0;
      inv_q      <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      pwd_q      <= pwd_d;
      found_q    <= found_d;
      idx_q      <= idx_d;
      timeout_q  <= timeout_d;
      inv_q      <= inv_d;
      cycles_q   <= cycles_d;
    end
  end

  assign worker_rst   = (state_q == S_RUN) ? '0 : '1;
  assign busy         = (state_q == S_LOAD) || (state_q == S_RUN);
  assign result_valid = (state_q == S_REPORT);
  assign worker_pwd   = pwd_q;
  assign found        = found_q;
  assign found_worker = idx_q;
  assign timeout      = timeout_q;
  assign pwd_invalid  = inv_q;
  assign cycles       = cycles_q;

endmodule

// File: tb/tb_crack_dispatcher.sv
module tb_crack_dispatcher;
  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int IW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   password = '0;
  logic [N-1:0]  worker_found = '0;
  logic [N-1:0]  worker_done = '0;
  logic [N-1:0]  worker_rst;
  logic [31:0]   worker_pwd;
  logic [6*N-1:0] worker_from, worker_to;
  logic          busy, result_valid, found, timeout, pwd_invalid;
  logic [IW-1:0] found_worker;
  logic [CW-1:0] cycles;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] f_arr [1:20];
  logic [N-1:0] d_arr [1:20];

  crack_dispatcher #(.NUM_WORKERS(N), .CYCLE_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .password(password),
    .worker_found(worker_found), .worker_done(worker_done),
    .worker_rst(worker_rst), .worker_pwd(worker_pwd),
    .worker_from(worker_from), .worker_to(worker_to),
    .busy(busy), .result_valid(result_valid), .found(found),
    .found_worker(found_worker), .timeout(timeout),
    .pwd_invalid(pwd_invalid), .cycles(cycles)
  );

  always #5 clk = ~clk;

  function automatic bit pwd_valid(input logic [31:0] p);
    for (int b = 0; b < 4; b++)
      if (p[8*b +: 8] < 48 || p[8*b +: 8] > 83) return 1'b0;
    return 1'b1;
  endfunction

  // Walk the per-cycle schedule in search order and stop at the first event.
  task automatic model(output bit ef, output int eidx, output bit eto, output int ecyc);
    ef = 0; eidx = 0; eto = 0; ecyc = 0;
    for (int k = 1; k <= CMAX; k++) begin
      if (f_arr[k] != 0) begin
        ef = 1;
        for (int i = N - 1; i >= 0; i--) if (f_arr[k][i]) eidx = i;
        ecyc = k;
        return;
      end
      if (d_arr[k] == {N{1'b1}}) begin
        ecyc = k;
        return;
      end
    end
    eto = 1;
    ecyc = CMAX;
  endtask

  task automatic clear_sched();
    for (int k = 1; k <= 20; k++) begin
      f_arr[k] = '0;
      d_arr[k] = '0;
    end
  endtask

  task automatic do_search(input logic [31:0] pwd, input bit poke_start);
    bit ef, eto, ev, got;
    int eidx, ecyc, run_n;
    ev = pwd_valid(pwd);
    model(ef, eidx, eto, ecyc);
    got = 0;
    run_n = 0;
    @(negedge clk);
    start = 1'b1;
    password = pwd;
    @(negedge clk);
    start = 1'b0;
    worker_found = '1;
    worker_done = '1;
    if (!ev) begin
      checks++;
      if (result_valid !== 1'b1 || pwd_invalid !== 1'b1 || found !== 1'b0 || timeout !== 1'b0 ||
          cycles !== '0 || busy !== 1'b0 || worker_rst !== '1 || worker_pwd !== pwd) begin
        failures++;
        $display("FAIL invalid_report: rv=%0d inv=%0d found=%0d to=%0d cyc=%0d busy=%0d wrst=%0h pwd=%0h, need rv=1 inv=1 found=0 to=0 cyc=0 busy=0 wrst=f pwd=%0h",
                 result_valid, pwd_invalid, found, timeout, cycles, busy, worker_rst, worker_pwd, pwd);
      end
      @(negedge clk);
      worker_found = '0;
      worker_done = '0;
      checks++;
      if (result_valid !== 1'b0 || pwd_invalid !== 1'b1 || busy !== 1'b0 || worker_rst !== '1) begin
        failures++;
        $display("FAIL invalid_after: rv=%0d inv=%0d busy=%0d wrst=%0h, need rv=0 inv=1 busy=0 wrst=f",
                 result_valid, pwd_invalid, busy, worker_rst);
      end
      return;
    end
    checks++;
    if (busy !== 1'b1 || worker_rst !== '1 || result_valid !== 1'b0 || worker_pwd !== pwd) begin
      failures++;
      $display("FAIL load1: busy=%0d wrst=%0h rv=%0d pwd=%0h, need busy=1 wrst=f rv=0 pwd=%0h",
               busy, worker_rst, result_valid, worker_pwd, pwd);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || worker_rst !== '1 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL load2: busy=%0d wrst=%0h rv=%0d, need busy=1 wrst=f rv=0", busy, worker_rst, result_valid);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        got = 1;
        run_n = k - 1;
        break;
      end
      checks++;
      if (busy !== 1'b1 || worker_rst !== '0 || cycles !== CW'(k - 1)) begin
        failures++;
        $display("FAIL run_state k=%0d: busy=%0d wrst=%0h cyc=%0d, need busy=1 wrst=0 cyc=%0d",
                 k, busy, worker_rst, cycles, k - 1);
      end
      worker_found = f_arr[k];
      worker_done = d_arr[k];
      start = (poke_start && k == 2);
    end
    worker_found = '0;
    worker_done = '0;
    start = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL no_result: result_valid=0 after 20 RUN cycles, need pulse after %0d", ecyc);
      return;
    end
    if (run_n != ecyc || found !== ef || (ef && found_worker !== IW'(eidx)) || (!ef && found_worker !== '0) ||
        timeout !== eto || pwd_invalid !== 1'b0 || cycles !== CW'(ecyc) || busy !== 1'b0 || worker_rst !== '1) begin
      failures++;
      $display("FAIL result: runs=%0d found=%0d idx=%0d to=%0d inv=%0d cyc=%0d busy=%0d wrst=%0h, need runs=%0d found=%0d idx=%0d to=%0d inv=0 cyc=%0d busy=0 wrst=f",
               run_n, found, found_worker, timeout, pwd_invalid, cycles, busy, worker_rst,
               ecyc, ef, ef ? eidx : 0, eto, ecyc);
    end
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || found !== ef || timeout !== eto || cycles !== CW'(ecyc)) begin
        failures++;
        $display("FAIL hold h=%0d: rv=%0d busy=%0d found=%0d to=%0d cyc=%0d, need rv=0 busy=0 found=%0d to=%0d cyc=%0d",
                 h, result_valid, busy, found, timeout, cycles, ef, eto, ecyc);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    logic [6*N-1:0] ef_from, ef_to;
    for (int i = 0; i < N; i++) begin
      ef_from[6*i +: 6] = 6'((36 * i) / N);
      ef_to[6*i +: 6]   = 6'((36 * (i + 1)) / N - 1);
    end
    checks++;
    if (worker_rst !== '1 || worker_pwd !== '0 || busy !== 1'b0 || result_valid !== 1'b0 || found !== 1'b0 ||
        found_worker !== '0 || timeout !== 1'b0 || pwd_invalid !== 1'b0 || cycles !== '0) begin
      failures++;
      $display("FAIL %s: wrst=%0h pwd=%0h busy=%0d rv=%0d found=%0d idx=%0d to=%0d inv=%0d cyc=%0d, need all clear and wrst=f",
               tag, worker_rst, worker_pwd, busy, result_valid, found, found_worker, timeout, pwd_invalid, cycles);
    end
    checks++;
    if (worker_from !== ef_from || worker_to !== ef_to) begin
      failures++;
      $display("FAIL %s_ranges: from=%0h to=%0h, need from=%0h to=%0h", tag, worker_from, worker_to, ef_from, ef_to);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_release");
  endtask

  task automatic test_found();
    clear_sched();
    f_arr[5] = 4'b0100;
    do_search(32'h30303030, 1'b0);
  endtask

  task automatic test_simultaneous();
    clear_sched();
    f_arr[4] = 4'b1010;
    do_search(32'h31323334, 1'b1);
  endtask

  task automatic test_exhausted();
    clear_sched();
    d_arr[3] = 4'b0101;
    for (int k = 7; k <= 20; k++) d_arr[k] = '1;
    do_search(32'h53303053, 1'b0);
  endtask

  task automatic test_priority();
    clear_sched();
    f_arr[6] = 4'b1000;
    d_arr[6] = '1;
    do_search(32'h30313233, 1'b0);
    clear_sched();
    d_arr[CMAX] = '1;
    do_search(32'h41424344, 1'b0);
  endtask

  task automatic test_invalid();
    clear_sched();
    do_search(32'h307A3030, 1'b0);
    do_search(32'h3030302F, 1'b0);
    do_search(32'h54303030, 1'b0);
  endtask

  task automatic test_timeout();
    clear_sched();
    do_search(32'h53535353, 1'b0);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1;
    password = 32'h32323232;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || worker_rst !== '0) begin
      failures++;
      $display("FAIL mid_reset_pre: busy=%0d wrst=%0h, need busy=1 wrst=0", busy, worker_rst);
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      if (h == 1) rst_n = 1'b1;
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_quiet h=%0d: rv=%0d busy=%0d, need rv=0 busy=0", h, result_valid, busy);
      end
    end
    clear_sched();
    f_arr[2] = 4'b0001;
    do_search(32'h32323232, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] pwd;
    int fc, dc;
    for (int t = 0; t < 25; t++) begin
      clear_sched();
      for (int b = 0; b < 4; b++) pwd[8*b +: 8] = 8'(48 + $urandom_range(0, 35));
      if ($urandom_range(0, 3) == 0) pwd[8*$urandom_range(0, 3) +: 8] = 8'($urandom_range(0, 255));
      fc = $urandom_range(0, 17);
      dc = $urandom_range(0, 17);
      for (int k = 1; k <= 20; k++) begin
        d_arr[k] = 4'($urandom_range(0, 15));
        if (d_arr[k] == 4'hF) d_arr[k] = 4'h7;
      end
      if (fc > 0) f_arr[fc] = 4'($urandom_range(1, 15));
      if (dc > 0) for (int k = dc; k <= 20; k++) d_arr[k] = '1;
      do_search(pwd, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    clear_sched();
    test_reset();
    test_found();
    test_simultaneous();
    test_exhausted();
    test_priority();
    test_invalid();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
